uart_frame_ctrl: RTL and testbench
==================================

// Module: uart_frame_ctrl
// PURPOSE
// Sequences one inference frame over the UART datapath. It drains exactly INPUT_NEURON bytes from the UART RX FIFO
// into the core input buffer, then pulses core_start and waits for core_done. It then reads OUT_BYTES result bytes
// and sends each one through the UART TX handshake (Send_Go / Tx_done). It sits between uart_block and the SNN core.
// PARAMETERS
// INPUT_NEURON  256  bytes per input frame (>=1)
// AW            8    input buffer address width, 2**AW >= INPUT_NEURON
// OUT_BYTES     10   result bytes returned per frame (>=1)
// RAW           4    result address width, 2**RAW >= OUT_BYTES
// PORTS
// CLK          in   1    clock
// RST_N        in   1    reset, asynchronous, active-low
// fifo_dout    in   8    RX FIFO data, valid the cycle after fifo_read
// fifo_empty   in   1    RX FIFO empty
// fifo_read    out  1    RX FIFO read strobe
// in_wr_en     out  1    core input buffer write enable
// in_wr_addr   out  AW   core input buffer write address
// in_wr_data   out  8    core input buffer write data
// core_start   out  1    one-cycle start pulse to core
// core_done    in   1    core finished (pulse or level; sampled only in WAIT_CORE)
// res_rd_addr  out  RAW  result memory address; sync read, data one cycle later
// res_rd_data  in   8    result memory data
// send_data    out  8    byte to UART TX
// Send_Go      out  1    one-cycle TX start pulse
// Tx_done      in   1    one-cycle TX complete pulse
// busy         out  1    high in every state except IDLE
// frame_done   out  1    one-cycle pulse after the last result byte's Tx_done
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, rd_cnt=wr_cnt=res_idx=0. Reset mid-frame aborts immediately; partial data is not resumed.
// - FSM: IDLE -> LOAD -> START -> WAIT_CORE -> RES_ADDR -> SEND_GO -> SEND_WAIT -> (RES_ADDR | IDLE).
// - IDLE: on !fifo_empty, go to LOAD. Nothing is read in this cycle.
// - LOAD: fifo_read = !fifo_empty && rd_cnt<INPUT_NEURON, combinational.
//   - Each read increments rd_cnt.
//   - A registered rd_pend causes, next cycle: in_wr_en=1, in_wr_addr=wr_cnt, in_wr_data=fifo_dout; then wr_cnt++.
//   - Sustains 1 byte/cycle. FIFO empty stalls with no read and no write; the state is held.
//   - When wr_cnt reaches INPUT_NEURON (last write done): clear counters, go to START.
//   - Bytes beyond INPUT_NEURON stay in the FIFO and begin the next frame.
// - START: core_start=1 for exactly one cycle, then WAIT_CORE.
// - WAIT_CORE: on core_done=1, set res_idx=0 and go to RES_ADDR. core_done in any other state is ignored.
// - RES_ADDR: res_rd_addr=res_idx, held through SEND_WAIT. Go to SEND_GO.
// - SEND_GO: latch send_data<=res_rd_data, Send_Go=1 for one cycle, go to SEND_WAIT.
// - SEND_WAIT: send_data is held stable. On Tx_done:
//   - if res_idx==OUT_BYTES-1, pulse frame_done and go to IDLE;
//   - else res_idx++ and go to RES_ADDR.
//   - Tx_done in any other state is ignored.
// - No timeouts; WAIT_CORE and SEND_WAIT wait indefinitely.
// - Counters never wrap: rd_cnt and wr_cnt saturate at INPUT_NEURON by construction.
// - fifo_read is never asserted outside LOAD. Send_Go is never asserted outside SEND_GO.
// TESTING
// - Full frame: push 256 bytes 0..255 with FIFO pre-filled -> 256 consecutive in_wr_en cycles, addr k data k; core_start 1 cycle after last write.
// - Stall: push 100 bytes, gap of 50 cycles, push 156 -> no fifo_read while empty; addr 0..255 contiguous; single core_start.
// - Result TX: core_done with results {0xA0..0xA9}, Tx_done 20 cycles after each Send_Go -> 10 Send_Go pulses, send_data A0..A9 in order; frame_done after the 10th Tx_done.
// - Spurious: core_done during LOAD, Tx_done during WAIT_CORE -> no state change, no outputs.
// - Back-to-back: push 512 bytes -> two complete frames; second LOAD starts only after the first frame_done.
// - Reset mid-LOAD at wr_cnt=37, then a fresh 256-byte frame -> outputs 0 during reset; new frame writes addr 0..255.

Source files
------------

// File: rtl/uart_frame_ctrl.sv
// Frame sequencer between the UART block and the SNN core: loads one input frame from the RX FIFO,
// kicks the core, then streams the result bytes back out through the UART TX handshake.
module uart_frame_ctrl #(
  parameter int unsigned INPUT_NEURON = 256,
  parameter int unsigned AW           = 8,
  parameter int unsigned OUT_BYTES    = 10,
  parameter int unsigned RAW          = 4
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [7:0]     fifo_dout,
  input  logic           fifo_empty,
  output logic           fifo_read,
  output logic           in_wr_en,
  output logic [AW-1:0]  in_wr_addr,
  output logic [7:0]     in_wr_data,
  output logic           core_start,
  input  logic           core_done,
  output logic [RAW-1:0] res_rd_addr,
  input  logic [7:0]     res_rd_data,
  output logic [7:0]     send_data,
  output logic           Send_Go,
  input  logic           Tx_done,
  output logic           busy,
  output logic           frame_done
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0]  LP_IN_MAX   = CW'(INPUT_NEURON);
  localparam logic [CW-1:0]  LP_IN_LAST  = CW'(INPUT_NEURON - 1);
  localparam logic [RAW-1:0] LP_RES_LAST = RAW'(OUT_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_CORE,
    S_RES_ADDR,
    S_SEND_GO,
    S_SEND_WAIT
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_rd_cnt;
  logic [CW-1:0]  r_wr_cnt;
  logic           r_rd_pend;
  logic [RAW-1:0] r_res_idx;
  logic [7:0]     r_send_data;
  logic           r_frame_done;
  logic           w_last_wr;
  logic           w_last_res;

  // The final input write is the cycle a pending read lands on the last buffer slot.
  assign w_last_wr  = r_rd_pend && (r_wr_cnt == LP_IN_LAST);
  assign w_last_res = (r_res_idx == LP_RES_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (!fifo_empty) w_next = S_LOAD;
      S_LOAD:      if (w_last_wr) w_next = S_START;
      S_START:     w_next = S_WAIT_CORE;
      S_WAIT_CORE: if (core_done) w_next = S_RES_ADDR;
      S_RES_ADDR:  w_next = S_SEND_GO;
      S_SEND_GO:   w_next = S_SEND_WAIT;
      S_SEND_WAIT: if (Tx_done) w_next = w_last_res ? S_IDLE : S_RES_ADDR;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_read   = (r_state == S_LOAD) && !fifo_empty && (r_rd_cnt < LP_IN_MAX);
    in_wr_en    = r_rd_pend;
    in_wr_addr  = r_wr_cnt[AW-1:0];
    in_wr_data  = r_rd_pend ? fifo_dout : '0;
    core_start  = (r_state == S_START);
    Send_Go     = (r_state == S_SEND_GO);
    busy        = (r_state != S_IDLE);
    res_rd_addr = r_res_idx;
    send_data   = r_send_data;
    frame_done  = r_frame_done;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_cnt     <= '0;
      r_wr_cnt     <= '0;
      r_rd_pend    <= 1'b0;
      r_res_idx    <= '0;
      r_send_data  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_rd_pend    <= fifo_read;
      r_frame_done <= (r_state == S_SEND_WAIT) && Tx_done && w_last_res;

      if (w_last_wr) begin
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
      end else begin
        if (fifo_read) r_rd_cnt <= r_rd_cnt + CW'(1);
        if (r_rd_pend) r_wr_cnt <= r_wr_cnt + CW'(1);
      end

      if ((r_state == S_WAIT_CORE) && core_done) begin
        r_res_idx <= '0;
      end else if ((r_state == S_SEND_WAIT) && Tx_done) begin
        r_res_idx <= w_last_res ? '0 : r_res_idx + RAW'(1);
      end

      if (r_state == S_SEND_GO) r_send_data <= res_rd_data;
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: stimulus pushes FIFO bytes and expected writes/TX bytes,
// a negedge monitor pops and compares whenever the DUT presents a write, start, send or frame_done.
module tb_uart_frame_ctrl;

  localparam int unsigned INPUT_NEURON = 256;
  localparam int unsigned AW           = 8;
  localparam int unsigned OUT_BYTES    = 10;
  localparam int unsigned RAW          = 4;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic [7:0]     fifo_dout = 8'h00;
  logic           fifo_empty;
  logic           fifo_read;
  logic           in_wr_en;
  logic [AW-1:0]  in_wr_addr;
  logic [7:0]     in_wr_data;
  logic           core_start;
  logic           core_done;
  logic [RAW-1:0] res_rd_addr;
  logic [7:0]     res_rd_data = 8'h00;
  logic [7:0]     send_data;
  logic           Send_Go;
  logic           Tx_done;
  logic           busy;
  logic           frame_done;

  logic core_done_m = 1'b0;
  logic spur_done   = 1'b0;
  logic tx_done_m   = 1'b0;
  logic spur_tx     = 1'b0;
  assign core_done = core_done_m | spur_done;
  assign Tx_done   = tx_done_m | spur_tx;

  always #5 CLK = ~CLK;

  uart_frame_ctrl #(
    .INPUT_NEURON(INPUT_NEURON),
    .AW          (AW),
    .OUT_BYTES   (OUT_BYTES),
    .RAW         (RAW)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .in_wr_en   (in_wr_en),
    .in_wr_addr (in_wr_addr),
    .in_wr_data (in_wr_data),
    .core_start (core_start),
    .core_done  (core_done),
    .res_rd_addr(res_rd_addr),
    .res_rd_data(res_rd_data),
    .send_data  (send_data),
    .Send_Go    (Send_Go),
    .Tx_done    (Tx_done),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // RX FIFO model: read data appears the cycle after fifo_read.
  logic [7:0]  fifo_mem [0:2047];
  logic [15:0] exp_wr   [0:2047];
  int unsigned fw  = 0;
  int unsigned fr  = 0;
  int unsigned pos = 0;
  assign fifo_empty = (fw == fr);

  always @(posedge CLK) begin
    if (fifo_read) begin
      fifo_dout <= fifo_mem[fr];
      fr        <= fr + 1;
    end
  end

  // Result memory, synchronous read.
  logic [7:0] res_mem [0:15];
  always @(posedge CLK) res_rd_data <= res_mem[res_rd_addr];

  logic [7:0]  exp_tx [0:63];
  int unsigned tx_w    = 0;
  int unsigned core_k  = 0;

  // Core model: 10 cycles after core_start, load results A0+16k..+9 and pulse core_done.
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (core_start) begin
        repeat (10) begin @(posedge CLK); #1; end
        for (int i = 0; i < OUT_BYTES; i++) begin
          res_mem[i]   = 8'hA0 + 8'(core_k * 16) + 8'(i);
          exp_tx[tx_w] = 8'hA0 + 8'(core_k * 16) + 8'(i);
          tx_w++;
        end
        core_k++;
        core_done_m = 1'b1;
        @(posedge CLK); #1;
        core_done_m = 1'b0;
      end
    end
  end

  // UART TX model: Tx_done 20 cycles after each Send_Go.
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (Send_Go) begin
        repeat (20) begin @(posedge CLK); #1; end
        tx_done_m = 1'b1;
        @(posedge CLK); #1;
        tx_done_m = 1'b0;
      end
    end
  end

  // Monitor state and counters.
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned wq_r = 0;
  int unsigned tx_r = 0;
  int unsigned wr_in_frame = 0;
  int unsigned sent_in_frame = 0;
  int unsigned frames_done = 0;
  int unsigned last_wr_cyc = 0;
  int unsigned last_txd_cyc = 0;
  logic        in_compute = 1'b0;
  logic        pending_tx = 1'b0;
  logic        end_done = 1'b0;
  logic [7:0]  cur_tx = 8'h00;

  // Owned by the stimulus process.
  logic        contig_chk = 1'b0;
  logic        end_req = 1'b0;
  int unsigned frames_target = 0;
  int unsigned deadline = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (!RST_N) begin
        chk("rst_ctrl_outs", 32'({fifo_read, in_wr_en, core_start, Send_Go, busy, frame_done}), 0);
        chk("rst_data_outs", 32'({in_wr_addr, in_wr_data, res_rd_addr, send_data}), 0);
        wr_in_frame   = 0;
        sent_in_frame = 0;
        in_compute    = 1'b0;
        pending_tx    = 1'b0;
      end else begin
        if (fifo_empty) chk("read_when_empty", 32'(fifo_read), 0);
        if (pending_tx) begin
          pending_tx = 1'b0;
          chk("send_data", 32'(send_data), 32'(exp_tx[tx_r]));
          cur_tx = exp_tx[tx_r];
          tx_r++;
          sent_in_frame++;
        end
        if (in_wr_en) begin
          if (wq_r == fw) begin
            chk("wr_unexpected", 32'(in_wr_en), 0);
          end else begin
            chk("wr_addr", 32'(in_wr_addr), 32'(exp_wr[wq_r][15:8]));
            chk("wr_data", 32'(in_wr_data), 32'(exp_wr[wq_r][7:0]));
            wq_r++;
          end
          chk("wr_during_compute", 32'(in_compute), 0);
          chk("busy_on_write", 32'(busy), 1);
          if (contig_chk && wr_in_frame > 0) chk("wr_gap", cyc - last_wr_cyc, 1);
          last_wr_cyc = cyc;
          wr_in_frame++;
        end
        if (core_start) begin
          chk("start_after_writes", wr_in_frame, INPUT_NEURON);
          chk("start_latency", cyc - last_wr_cyc, 1);
          wr_in_frame = 0;
          in_compute  = 1'b1;
        end
        if (Send_Go) begin
          if (tx_r == tx_w) chk("send_unexpected", 32'(Send_Go), 0);
          else pending_tx = 1'b1;
        end
        if (tx_done_m) begin
          chk("send_data_hold", 32'(send_data), 32'(cur_tx));
          last_txd_cyc = cyc;
        end
        if (frame_done) begin
          chk("frame_sent_cnt", sent_in_frame, OUT_BYTES);
          chk("frame_done_latency", cyc - last_txd_cyc, 1);
          chk("busy_at_frame_done", 32'(busy), 0);
          frames_done++;
          sent_in_frame = 0;
          in_compute    = 1'b0;
        end
      end
      if (cyc == deadline && frames_done < frames_target)
        chk("frame_timeout", frames_done, frames_target);
      if (end_req && !end_done) begin
        chk("all_writes_seen", wq_r, fw);
        chk("all_tx_seen", tx_r, tx_w);
        chk("frames_total", frames_done, 5);
        chk("fifo_drained", fr, fw);
        end_done = 1'b1;
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[fw] = b;
    exp_wr[fw]   = {pos[7:0], b};
    pos          = (pos + 1) % INPUT_NEURON;
    fw++;
  endtask

  task automatic wait_frames(input int unsigned target, input int unsigned budget);
    frames_target = target;
    deadline      = cyc + budget;
    while (frames_done < target && cyc <= deadline) tick(1);
  endtask

  initial begin
    RST_N = 1'b0;
    tick(4);
    RST_N = 1'b1;
    tick(2);

    // Full frame from a pre-filled FIFO.
    contig_chk = 1'b1;
    for (int i = 0; i < 256; i++) push(8'(i));
    wait_frames(1, 2000);
    contig_chk = 1'b0;

    // Stalled load with a spurious core_done in the gap, spurious Tx_done during WAIT_CORE.
    for (int i = 0; i < 100; i++) push(8'(i * 3 + 7));
    tick(126);
    spur_done = 1'b1;
    tick(1);
    spur_done = 1'b0;
    tick(24);
    for (int i = 100; i < 256; i++) push(8'(i * 3 + 7));
    for (int i = 0; i < 400 && !core_start; i++) tick(1);
    tick(2);
    spur_tx = 1'b1;
    tick(1);
    spur_tx = 1'b0;
    wait_frames(2, 2000);

    // Back-to-back frames from one 512-byte burst.
    for (int i = 0; i < 512; i++) push(8'(i) ^ 8'h5A);
    wait_frames(4, 4000);

    // Reset after 37 bytes loaded, then a fresh frame.
    for (int i = 0; i < 37; i++) push(8'(i + 200));
    for (int i = 0; i < 200 && wr_in_frame < 37; i++) tick(1);
    tick(3);
    RST_N = 1'b0;
    tick(3);
    RST_N = 1'b1;
    pos = 0;
    tick(2);
    for (int i = 0; i < 256; i++) push(8'(255 - i));
    wait_frames(5, 2000);

    tick(3);
    end_req = 1'b1;
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
